// File: rtl/modadd_pkg.sv
// ----------------------------------------------------------------------------
// modadd_pkg
// Shared constants and stage payload records for modular_adder_pipe.
//   MODADD_WIDTH      default operand width
//   MODADD_STAGES     pipeline depth supported by this revision
//   MODADD_MAX_WIDTH  widest operand the payload records can carry
//   stage1_t          registered output of the preprocess stage
//   stage2_t          registered output of the carry (prefix) stage
// Records are sized for MODADD_MAX_WIDTH; a narrower instance uses the low
// WIDTH bits of each field and keeps the upper bits at zero.
// ----------------------------------------------------------------------------
package modadd_pkg;

    localparam int unsigned MODADD_WIDTH     = 7;
    localparam int unsigned MODADD_STAGES    = 3;
    localparam int unsigned MODADD_MAX_WIDTH = 32;

    typedef logic [MODADD_MAX_WIDTH-1:0] word_t;

    typedef struct packed {
        word_t k;       // modulus offset, carried with the transaction
        word_t g;       // a & b
        word_t p;       // a | b
        word_t h;       // a ^ b
        word_t gk;      // a' & b'
        word_t pk;      // a' | b'
        word_t hk;      // a' ^ b'
        logic  ck_top;  // carry-save carry out of the top bit (weight 2^N)
        logic  err;     // operand set is outside the modulus range
    } stage1_t;

    typedef struct packed {
        word_t h;       // a ^ b
        word_t c;       // carries into each bit of a + b
        word_t hk;      // a' ^ b'
        word_t ck;      // carries into each bit of a + b + k
        logic  cout_k;  // a + b + k >= 2^N
        logic  err;
    } stage2_t;

endpackage

// File: rtl/mod_preprocess.sv
// ----------------------------------------------------------------------------
// mod_preprocess
// Combinational first stage of the modular adder. Forms generate/propagate/
// half-sum terms for a + b, and compresses a + b + k into two operands
// a', b' (carry-save) with the matching g', p', h' terms.
// Ports:
//   a, b, k      operands and modulus offset (WIDTH bits)
//   g, p, h      a&b, a|b, a^b
//   gk, pk, hk   a'&b', a'|b', a'^b'
//   ck_top       carry-save carry leaving the top bit (weight 2^WIDTH)
// ----------------------------------------------------------------------------
module mod_preprocess
    import modadd_pkg::*;
#(
    parameter int unsigned WIDTH = MODADD_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] h,
    output logic [WIDTH-1:0] gk,
    output logic [WIDTH-1:0] pk,
    output logic [WIDTH-1:0] hk,
    output logic             ck_top
);

    logic [WIDTH-1:0] ak;
    logic [WIDTH-1:0] bk;

    always_comb begin
        g  = a & b;
        p  = a | b;
        h  = g ^ p;
        ak = h ^ k;
        // Majority carry of bit i-1 lands at bit i; bit 0 receives none.
        bk = '0;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            bk[i] = k[i-1] ? p[i-1] : g[i-1];
        end
        ck_top = k[WIDTH-1] ? p[WIDTH-1] : g[WIDTH-1];
        gk = ak & bk;
        pk = ak | bk;
        hk = gk ^ pk;
    end

endmodule

// File: rtl/modular_adder_pipe.sv
// ----------------------------------------------------------------------------
// modular_adder_pipe
// Three-stage pipelined modular adder: sum = (a + b) mod M, M = 2^WIDTH - k.
// Stage 1 registers preprocess terms, stage 2 registers both carry vectors
// (Sklansky prefix), stage 3 selects a+b or a+b+k-2^WIDTH and drives outputs.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid / in_ready    input handshake for a, b, k
//   out_valid / out_ready  output handshake for sum, err
//   sum                    (a + b) mod M, zero when err is set
//   err                    a >= M, b >= M or k = 2^WIDTH - 1
//   txn_count              completed output transfers, wraps at 2^16
// ----------------------------------------------------------------------------
module modular_adder_pipe
    import modadd_pkg::*;
#(
    parameter int unsigned WIDTH  = MODADD_WIDTH,
    parameter int unsigned STAGES = MODADD_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             err,
    output logic [15:0]      txn_count
);

    localparam int unsigned LEVELS = $clog2(WIDTH);

    if (STAGES != MODADD_STAGES) begin : g_bad_stages
        $error("modular_adder_pipe: STAGES must be %0d", MODADD_STAGES);
    end
    if (WIDTH < 4 || WIDTH > MODADD_MAX_WIDTH) begin : g_bad_width
        $error("modular_adder_pipe: WIDTH must be 4..%0d", MODADD_MAX_WIDTH);
    end

    // Group generate of bits [i:0] for every i, Sklansky prefix tree.
    function automatic logic [WIDTH-1:0] group_gen(input logic [WIDTH-1:0] g_in,
                                                   input logic [WIDTH-1:0] p_in);
        logic [WIDTH-1:0] gg, pp, gn, pn;
        int unsigned j;
        gg = g_in;
        pp = p_in;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            gn = gg;
            pn = pp;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (((i >> l) & 1) != 0) begin
                    j     = ((i >> l) << l) - 1;
                    gn[i] = gg[i] | (pp[i] & gg[j]);
                    pn[i] = pp[i] & pp[j];
                end
            end
            gg = gn;
            pp = pn;
        end
        return gg;
    endfunction

    // ---------------- handshake ----------------
    logic s1_valid, s2_valid;
    logic s1_load, s2_load, s3_load;

    assign s3_load  = !out_valid | out_ready;
    assign s2_load  = !s2_valid  | s3_load;
    assign s1_load  = !s1_valid  | s2_load;
    assign in_ready = s1_load;

    // ---------------- stage 1 ----------------
    logic [WIDTH-1:0] pre_g, pre_p, pre_h, pre_gk, pre_pk, pre_hk;
    logic             pre_ck_top;
    logic [WIDTH:0]   modulus;
    stage1_t          s1_d, s1_q;

    mod_preprocess #(.WIDTH(WIDTH)) u_pre (
        .a      (a),
        .b      (b),
        .k      (k),
        .g      (pre_g),
        .p      (pre_p),
        .h      (pre_h),
        .gk     (pre_gk),
        .pk     (pre_pk),
        .hk     (pre_hk),
        .ck_top (pre_ck_top)
    );

    always_comb begin
        modulus     = {1'b1, {WIDTH{1'b0}}} - {1'b0, k};
        s1_d        = '0;
        s1_d.k      = word_t'(k);
        s1_d.g      = word_t'(pre_g);
        s1_d.p      = word_t'(pre_p);
        s1_d.h      = word_t'(pre_h);
        s1_d.gk     = word_t'(pre_gk);
        s1_d.pk     = word_t'(pre_pk);
        s1_d.hk     = word_t'(pre_hk);
        s1_d.ck_top = pre_ck_top;
        s1_d.err    = ({1'b0, a} >= modulus) | ({1'b0, b} >= modulus) | (&k);
    end

    // ---------------- stage 2 ----------------
    logic [WIDTH-1:0] gg_plain, gg_k, c_plain, c_k;
    stage2_t          s2_d, s2_q;

    always_comb begin
        gg_plain    = group_gen(s1_q.g[WIDTH-1:0],  s1_q.p[WIDTH-1:0]);
        gg_k        = group_gen(s1_q.gk[WIDTH-1:0], s1_q.pk[WIDTH-1:0]);
        c_plain     = gg_plain << 1;
        c_k         = gg_k << 1;
        s2_d        = '0;
        s2_d.h      = word_t'(s1_q.h[WIDTH-1:0]);
        s2_d.c      = word_t'(c_plain);
        s2_d.hk     = word_t'(s1_q.hk[WIDTH-1:0]);
        s2_d.ck     = word_t'(c_k);
        // a + b + k overflows if either the carry-save top carry or the
        // a' + b' addition carries out; for in-range operands never both.
        s2_d.cout_k = gg_k[WIDTH-1] | s1_q.ck_top;
        s2_d.err    = s1_q.err;
    end

    // ---------------- stage 3 ----------------
    logic [WIDTH-1:0] sum_d;

    always_comb begin
        sum_d = '0;
        if (!s2_q.err) begin
            if (s2_q.cout_k) begin
                sum_d = s2_q.hk[WIDTH-1:0] ^ s2_q.ck[WIDTH-1:0];
            end else begin
                sum_d = s2_q.h[WIDTH-1:0] ^ s2_q.c[WIDTH-1:0];
            end
        end
    end

    // Padding bits above WIDTH in the payload records are never read.
    logic unused_pad;
    assign unused_pad = ^{s1_q, s2_q};

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            sum       <= '0;
            err       <= 1'b0;
            txn_count <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_q <= s2_d;
            end
            if (s3_load) begin
                out_valid <= s2_valid;
                if (s2_valid) begin
                    sum <= sum_d;
                    err <= s2_q.err;
                end
            end
            if (out_valid && out_ready) begin
                txn_count <= txn_count + 16'd1;
            end
        end
    end

endmodule
